// File: rtl/sine_quarter_reader.sv
// Full-wave sine sample generator driven by a quarter-wave ROM: a tick divider
// advances a phase accumulator, which is folded into a ROM address plus sign.
module sine_quarter_reader #(
  parameter int ROM_DEPTH = 64,
  parameter int ROM_WIDTH = 8,
  parameter int CNT_DIV   = 10,
  localparam int ADDRW    = $clog2(4 * ROM_DEPTH),
  localparam int AW       = $clog2(ROM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ADDRW-1:0]     step,
  output logic [AW-1:0]        rom_addr,
  input  logic [ROM_WIDTH-1:0] rom_data,
  output logic [ROM_WIDTH:0]   sample,
  output logic                 sample_valid,
  output logic                 phase_wrap
);

  localparam int CW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_DIV - 1);

  logic [CW-1:0]    cnt;
  logic [ADDRW-1:0] phase;
  logic             negate;
  logic             pending;

  logic             tick;
  logic [ADDRW:0]   phase_sum;
  logic [ADDRW-1:0] next_phase;
  logic             carry;
  logic [1:0]       quad;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    next_addr;
  logic [ROM_WIDTH:0] magnitude;

  always_comb begin
    tick       = en && (cnt == CNT_LAST);
    phase_sum  = {1'b0, phase} + {1'b0, step};
    next_phase = phase_sum[ADDRW-1:0];
    carry      = phase_sum[ADDRW];
    quad       = next_phase[ADDRW-1:ADDRW-2];
    idx        = next_phase[AW-1:0];
    // Odd quadrants walk the table backwards; the half-sample offset of the
    // table means a plain mirror needs no endpoint correction.
    next_addr  = quad[0] ? (AW'(ROM_DEPTH - 1) - idx) : idx;
    magnitude  = {1'b0, rom_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      phase        <= '0;
      rom_addr     <= '0;
      negate       <= 1'b0;
      pending      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      // The ROM read launched on a tick always completes one edge later,
      // even if en has dropped in between.
      pending      <= tick;
      sample_valid <= pending;
      phase_wrap   <= tick && carry;
      if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (tick) begin
        phase    <= next_phase;
        rom_addr <= next_addr;
        negate   <= quad[1];
      end
      if (pending) begin
        sample <= negate ? -magnitude : magnitude;
      end
    end
  end

endmodule

// File: tb/tb_sine_quarter_reader.sv
// Directed bench for sine_quarter_reader with default parameters and a
// behavioural ROM whose entry i holds 4*i+3 (entry 63 is full scale 255).
module tb_sine_quarter_reader;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] step;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic [8:0] sample;
  logic       sample_valid;
  logic       phase_wrap;

  int checks = 0;
  int errors = 0;

  sine_quarter_reader dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .step         (step),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase_wrap   (phase_wrap)
  );

  // Clock and asynchronous ROM.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [5:0] a);
    return 8'(4 * int'(a) + 3);
  endfunction

  always_comb rom_data = rom_val(rom_addr);

  function automatic logic [8:0] signed_of(input logic [5:0] a, input bit neg);
    logic [8:0] m;
    m = {1'b0, rom_val(a)};
    return neg ? 9'(-m) : m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Advance until sample_valid is seen; n = edges taken, wr = phase_wrap pulses.
  task automatic wait_valid(output int n, output int wr);
    n  = 0;
    wr = 0;
    do begin
      tick_clk();
      n++;
      if (phase_wrap) wr++;
    end while (!sample_valid && n < 200);
    chk("valid_seen", 32'(sample_valid), 32'd1);
  endtask

  initial begin
    int n;
    int wr;
    int wr_total;
    int bad;
    int p;
    int q;
    logic [5:0] ea;

    // Reset state.
    rst  = 1'b1;
    en   = 1'b0;
    step = 8'd0;
    repeat (3) tick_clk();
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_wrap", 32'(phase_wrap), 32'd0);

    // step=1: tick on the tenth enabled edge, sample one edge later.
    rst  = 1'b0;
    en   = 1'b1;
    step = 8'd1;
    for (int i = 1; i <= 9; i++) begin
      tick_clk();
      chk("pre_tick_valid", 32'(sample_valid), 32'd0);
      chk("pre_tick_addr", 32'(rom_addr), 32'd0);
    end
    tick_clk();
    chk("tick10_addr", 32'(rom_addr), 32'd1);
    chk("tick10_valid", 32'(sample_valid), 32'd0);
    tick_clk();
    chk("first_valid", 32'(sample_valid), 32'd1);
    chk("first_sample", 32'(sample), 32'h007);
    tick_clk();
    chk("pulse_width", 32'(sample_valid), 32'd0);
    chk("sample_hold", 32'(sample), 32'h007);
    wait_valid(n, wr);
    chk("gap_rest", 32'(n), 32'd9);
    chk("second_sample", 32'(sample), 32'h00B);
    chk("second_addr", 32'(rom_addr), 32'd2);
    wait_valid(n, wr);
    chk("gap_10", 32'(n), 32'd10);
    chk("third_sample", 32'(sample), 32'h00F);

    // Reset, then step=64 visits each quadrant boundary.
    rst  = 1'b1;
    step = 8'd64;
    tick_clk();
    chk("rst2_addr", 32'(rom_addr), 32'd0);
    chk("rst2_sample", 32'(sample), 32'd0);
    rst = 1'b0;
    wait_valid(n, wr);
    chk("q1_gap", 32'(n), 32'd11);
    chk("q1_addr", 32'(rom_addr), 32'd63);
    chk("q1_sample", 32'(sample), 32'h0FF);
    chk("q1_wrap", 32'(wr), 32'd0);
    wait_valid(n, wr);
    chk("q2_addr", 32'(rom_addr), 32'd0);
    chk("q2_sample", 32'(sample), 32'h1FD);
    chk("q2_wrap", 32'(wr), 32'd0);
    wait_valid(n, wr);
    chk("q3_addr", 32'(rom_addr), 32'd63);
    chk("q3_sample", 32'(sample), 32'h101);
    chk("q3_wrap", 32'(wr), 32'd0);
    wait_valid(n, wr);
    chk("q0_addr", 32'(rom_addr), 32'd0);
    chk("q0_sample", 32'(sample), 32'h003);
    chk("q0_wrap", 32'(wr), 32'd1);

    // One full period at step=1 starting from phase 0.
    step     = 8'd1;
    wr_total = 0;
    for (int k = 0; k < 256; k++) begin
      wait_valid(n, wr);
      wr_total += wr;
      p  = (k + 1) % 256;
      q  = p / 64;
      ea = (q % 2 == 1) ? 6'(63 - (p % 64)) : 6'(p % 64);
      chk("sweep_gap", 32'(n), 32'd10);
      chk("sweep_addr", 32'(rom_addr), 32'(ea));
      chk("sweep_sample", 32'(sample), 32'(signed_of(ea, q >= 2)));
    end
    chk("sweep_wraps", 32'(wr_total), 32'd1);

    // en drops right after a tick: pending sample completes, then all holds.
    repeat (9) tick_clk();
    chk("hold_tick_addr", 32'(rom_addr), 32'd1);
    en = 1'b0;
    tick_clk();
    chk("hold_pending_valid", 32'(sample_valid), 32'd1);
    chk("hold_pending_sample", 32'(sample), 32'h007);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick_clk();
      if (sample_valid || rom_addr != 6'd1 || sample != 9'h007) bad++;
    end
    chk("hold_frozen", 32'(bad), 32'd0);
    en = 1'b1;
    wait_valid(n, wr);
    chk("resume_gap", 32'(n), 32'd11);
    chk("resume_addr", 32'(rom_addr), 32'd2);
    chk("resume_sample", 32'(sample), 32'h00B);

    // Reset the cycle after a tick discards the pending sample.
    repeat (9) tick_clk();
    chk("pre_rst_addr", 32'(rom_addr), 32'd3);
    rst  = 1'b1;
    step = 8'd0;
    tick_clk();
    chk("midrst_valid", 32'(sample_valid), 32'd0);
    chk("midrst_sample", 32'(sample), 32'd0);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    chk("midrst_wrap", 32'(phase_wrap), 32'd0);
    rst = 1'b0;
    tick_clk();
    chk("midrst_no_pending", 32'(sample_valid), 32'd0);
    wait_valid(n, wr);
    chk("step0_gap", 32'(n), 32'd10);
    chk("step0_sample_a", 32'(sample), 32'h003);
    chk("step0_addr", 32'(rom_addr), 32'd0);
    wait_valid(n, wr);
    chk("step0_gap2", 32'(n), 32'd10);
    chk("step0_sample_b", 32'(sample), 32'h003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_quarter_reader.md
SINE_QUARTER_READER -- requirements
Module: sine_quarter_reader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 64, entries in the quarter-wave sine ROM (power of two, >=4).
REQ-002 SHALL have parameter ROM_WIDTH, default 8, unsigned magnitude width of each ROM entry.
REQ-003 SHALL have parameter CNT_DIV, default 10, clock cycles per sample tick (>=1).
REQ-004 SHALL derive localparam ADDRW = $clog2(4*ROM_DEPTH), the full-period phase width, and AW = $clog2(ROM_DEPTH).
REQ-005 clk  input  1  rising-edge clock; one clock domain.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 en  input  1  enables the tick divider; low freezes the divider and phase.
REQ-008 step  input  ADDRW  phase increment added per tick.
REQ-009 rom_addr  output  AW  registered address to the asynchronous quarter-wave ROM.
REQ-010 rom_data  input  ROM_WIDTH  combinational ROM read data for rom_addr.
REQ-011 sample  output  ROM_WIDTH+1  signed full-wave sample, registered.
REQ-012 sample_valid  output  1  one-cycle pulse when sample is updated.
REQ-013 phase_wrap  output  1  one-cycle pulse when the phase accumulator wraps past 4*ROM_DEPTH-1.

Function
REQ-014 Divider: cnt counts 0..CNT_DIV-1 on each clk edge with en=1; tick = en && cnt==CNT_DIV-1; cnt returns to 0 on tick; cnt holds when en=0.
REQ-015 CNT_DIV=1: tick on every enabled cycle.
REQ-016 Phase: on tick edge, phase <= (phase + step) mod 4*ROM_DEPTH; carry out of ADDRW bits sets phase_wrap=1 for the following cycle only.
REQ-017 step sampled only on tick edges; changes between ticks have no effect until the next tick.
REQ-018 Quadrant q = next_phase[ADDRW-1:ADDRW-2], idx = next_phase[AW-1:0].
REQ-019 On the tick edge rom_addr <= idx for q=0,2; rom_addr <= ROM_DEPTH-1-idx for q=1,3; registered negate flag <= (q>=2).
REQ-020 One edge after the tick edge: sample <= negate ? -{1'b0,rom_data} : {1'b0,rom_data}; sample_valid=1 for exactly that cycle.
REQ-021 Latency: tick edge N -> rom_addr/phase updated after N; sample/sample_valid updated after edge N+1.
REQ-022 Table is a half-sample-offset quarter wave, so the mirror at q=1,3 needs no endpoint special-casing.
REQ-023 Negative full-scale: rom_data=2^ROM_WIDTH-1 gives sample = -(2^ROM_WIDTH-1); no saturation and no overflow within ROM_WIDTH+1 bits.
REQ-024 Between sample_valid pulses sample holds its value; rom_addr holds between ticks.
REQ-025 en deasserted mid-interval: cnt, phase, rom_addr, sample all hold; pending sample of an already-occurred tick still completes on edge N+1.
REQ-026 step=0: ticks still produce sample_valid pulses with a constant sample.

Reset
REQ-027 rst=1 at a clk edge: cnt=0, phase=0, rom_addr=0, negate=0, sample=0, sample_valid=0, phase_wrap=0; rst has priority over en and tick.
REQ-028 Reset mid-operation discards any pending sample; first tick after release occurs CNT_DIV enabled edges later.

Verification
REQ-029 Defaults, step=1, en=1 after reset: tenth enabled edge -> phase=1, rom_addr=1; next edge sample=+rom[1], sample_valid pulse of one cycle; pulses 10 cycles apart.
REQ-030 step=64 from phase 0: successive rom_addr/sign = 63/+, 0/-, 63/-, 0/+; phase_wrap pulses on the fourth tick only.
REQ-031 step=1, run 256 ticks: rom_addr ascends 0..63 (q0), descends 63..0 (q1), repeats with sign negative (q2,q3); one phase_wrap per period.
REQ-032 en low for 25 cycles between ticks: no sample_valid, cnt resumes from held value, next tick delayed by exactly 25 cycles.
REQ-033 rst asserted the cycle after a tick: no sample_valid follows; all outputs 0; step=0 afterwards gives constant sample=+rom[0] each tick.
REQ-034 rom_data=255 with q=2: sample = -255 (9'h101); with q=0: sample = +255 (9'h0FF).
